// File: rtl/noc_pkg.sv
// Shared NoC definitions: packetizer FSM states and header field layout.
// The router arbiter decodes headers with the same offset helpers.
package noc_pkg;

   typedef enum logic [1:0] {
      PKT_IDLE    = 2'd0,
      PKT_HEADER  = 2'd1,
      PKT_PAYLOAD = 2'd2
   } pkt_state_e;

   // Header layout from bit 0 upward: dest_x, dest_y, src_x, src_y, len, zero fill.
   function automatic int hdr_dest_x_lsb();
      return 0;
   endfunction

   function automatic int hdr_dest_y_lsb(input int x_w);
      return x_w;
   endfunction

   function automatic int hdr_src_x_lsb(input int x_w, input int y_w);
      return x_w + y_w;
   endfunction

   function automatic int hdr_src_y_lsb(input int x_w, input int y_w);
      return 2 * x_w + y_w;
   endfunction

   function automatic int hdr_len_lsb(input int x_w, input int y_w);
      return 2 * x_w + 2 * y_w;
   endfunction

   function automatic int hdr_bits(input int x_w, input int y_w, input int len_w);
      return 2 * x_w + 2 * y_w + len_w;
   endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready, last and a one-bit user sideband.
interface axis_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport m (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport s (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Wraps a payload stream into NoC packets: one header flit stamped with
// destination, source and length, followed by cmd_len payload flits.
//
// state       | meaning
// ------------+----------------------------------------------------------
// PKT_IDLE    | cmd_ready high, waiting for a packet command
// PKT_HEADER  | command latched, header goes into the output register
// PKT_PAYLOAD | forwarding payload beats, counter tracks remaining flits
module axis_packetizer
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH              = 32,
   parameter int MAX_ROUTERS_X           = 4,
   parameter int MAX_ROUTERS_Y           = 4,
   parameter int ROUTER_X                = 0,
   parameter int ROUTER_Y                = 0,
   parameter int MAXIMUM_PACKAGES_NUMBER = 5,
   localparam int X_W   = $clog2(MAX_ROUTERS_X),
   localparam int Y_W   = $clog2(MAX_ROUTERS_Y),
   localparam int LEN_W = $clog2(MAXIMUM_PACKAGES_NUMBER)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [X_W-1:0]   cmd_dest_x,
   input  logic [Y_W-1:0]   cmd_dest_y,
   input  logic [LEN_W-1:0] cmd_len,
   axis_if.s                in,
   axis_if.m                out,
   output logic             err_o
);

   localparam int OFF_DX  = hdr_dest_x_lsb();
   localparam int OFF_DY  = hdr_dest_y_lsb(X_W);
   localparam int OFF_SX  = hdr_src_x_lsb(X_W, Y_W);
   localparam int OFF_SY  = hdr_src_y_lsb(X_W, Y_W);
   localparam int OFF_LEN = hdr_len_lsb(X_W, Y_W);

   localparam logic [X_W-1:0]   SRC_X   = X_W'(ROUTER_X);
   localparam logic [Y_W-1:0]   SRC_Y   = Y_W'(ROUTER_Y);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAXIMUM_PACKAGES_NUMBER - 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   pkt_state_e state_q, state_d;

   logic [X_W-1:0]        dest_x_q;
   logic [Y_W-1:0]        dest_y_q;
   logic [LEN_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  tvalid_q;
   logic                  tlast_q;

   logic                  cmd_fire;
   logic                  len_ok;
   logic                  out_free;
   logic                  hdr_load;
   logic                  in_ready;
   logic                  beat_fire;
   logic [DATA_WIDTH-1:0] hdr;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign len_ok    = (cmd_len != '0) && (cmd_len <= LEN_MAX);
   assign out_free  = !tvalid_q || out.tready;
   assign beat_fire = in_ready && in.tvalid;

   // The counter still holds the latched length while in PKT_HEADER.
   always_comb begin
      hdr                        = '0;
      hdr[OFF_DX  +: X_W]        = dest_x_q;
      hdr[OFF_DY  +: Y_W]        = dest_y_q;
      hdr[OFF_SX  +: X_W]        = SRC_X;
      hdr[OFF_SY  +: Y_W]        = SRC_Y;
      hdr[OFF_LEN +: LEN_W]      = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= PKT_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      hdr_load  = 1'b0;
      case (state_q)
         PKT_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && len_ok) state_d = PKT_HEADER;
         end
         PKT_HEADER: begin
            if (out_free) begin
               hdr_load = 1'b1;
               state_d  = PKT_PAYLOAD;
            end
         end
         PKT_PAYLOAD: begin
            in_ready = out_free;
            if (in.tvalid && out_free && (cnt_q == LEN_ONE)) state_d = PKT_IDLE;
         end
         default: state_d = PKT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_x_q <= '0;
         dest_y_q <= '0;
         cnt_q    <= '0;
         err_o    <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         err_o <= cmd_fire && !len_ok;

         if (cmd_fire && len_ok) begin
            dest_x_q <= cmd_dest_x;
            dest_y_q <= cmd_dest_y;
            cnt_q    <= cmd_len;
         end else if (beat_fire) begin
            cnt_q <= cnt_q - LEN_ONE;
         end

         // Single output register; a pending flit is only replaced once taken.
         if (hdr_load) begin
            tdata_q  <= hdr;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
         end else if (beat_fire) begin
            tdata_q  <= in.tdata;
            tvalid_q <= 1'b1;
            tlast_q  <= (cnt_q == LEN_ONE);
         end else if (out.tready) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign out.tdata  = tdata_q;
   assign out.tvalid = tvalid_q;
   assign out.tlast  = tlast_q;
   assign out.tuser  = 1'b0;
   assign in.tready  = in_ready;

endmodule
